// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, key schedule run
// forward to rk10 on the fly and then stepped back down to rk0 alongside the rounds.

// One state column: InvSubBytes, AddRoundKey, then InvMixColumns.
module aes128_dec_lane (
  input  logic [31:0] i_col,
  input  logic [31:0] i_rk,
  output logic [31:0] o_add,
  output logic [31:0] o_mix
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic logic [7:0] isb(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = x;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  logic [7:0] w_b [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_b[i] = isb(i_col[31-8*i -: 8]) ^ i_rk[31-8*i -: 8];
  end

  assign o_add = {w_b[0], w_b[1], w_b[2], w_b[3]};
  assign o_mix = {
    gm(w_b[0], 4'hE) ^ gm(w_b[1], 4'hB) ^ gm(w_b[2], 4'hD) ^ gm(w_b[3], 4'h9),
    gm(w_b[0], 4'h9) ^ gm(w_b[1], 4'hE) ^ gm(w_b[2], 4'hB) ^ gm(w_b[3], 4'hD),
    gm(w_b[0], 4'hD) ^ gm(w_b[1], 4'h9) ^ gm(w_b[2], 4'hE) ^ gm(w_b[3], 4'hB),
    gm(w_b[0], 4'hB) ^ gm(w_b[1], 4'hD) ^ gm(w_b[2], 4'h9) ^ gm(w_b[3], 4'hE)};
endmodule

module aes128_decrypt_iter #(
  parameter bit WIPE_ON_IDLE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_text_128,
  input  logic [127:0] cipher_key_128,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plan_text_128,
  output logic         busy
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 32;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef enum logic [2:0] {S_IDLE, S_KEXP, S_INIT, S_ROUND, S_FINAL, S_DONE} state_t;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Undo one expansion step: recover w3..w1 by XOR, then w0 needs the old w3.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]  ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] ixt(input logic [7:0] x);
    return x[0] ? (((x ^ 8'h1b) >> 1) | 8'h80) : (x >> 1);
  endfunction

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [127:0] r_key, w_key_nxt;
  logic [127:0] r_pt, w_pt_nxt;
  logic [7:0]   r_rcon, w_rcon_nxt, w_rc_dn;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic         r_out_valid, w_ov_nxt;
  logic         r_in_ready;

  logic [0:NUM_LANES-1][VEC_W-1:0] w_st, w_shr, w_rk, w_add, w_mix;

  assign w_st    = r_state;
  assign w_rk    = r_key;
  assign w_rc_dn = ixt(r_rcon);

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    w_shr = '0;
    for (int c = 0; c < NUM_LANES; c++)
      for (int r = 0; r < 4; r++)
        w_shr[c][31-8*r -: 8] = w_st[(c + 4 - r) % 4][31-8*r -: 8];
  end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_lane
    aes128_dec_lane u_lane (
      .i_col (w_shr[c]),
      .i_rk  (w_rk[c]),
      .o_add (w_add[c]),
      .o_mix (w_mix[c])
    );
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_rcon_nxt  = r_rcon;
    w_cnt_nxt   = r_cnt;
    w_pt_nxt    = r_pt;
    w_ov_nxt    = r_out_valid;
    unique case (r_fsm)
      S_IDLE: if (in_valid && r_in_ready) begin
        w_state_nxt = cipher_text_128;
        w_key_nxt   = cipher_key_128;
        w_rcon_nxt  = 8'h01;
        w_cnt_nxt   = 4'd0;
        w_fsm_nxt   = S_KEXP;
      end
      S_KEXP: begin
        w_key_nxt  = key_fwd(r_key, r_rcon);
        w_rcon_nxt = xt(r_rcon);
        w_cnt_nxt  = r_cnt + 4'd1;
        if (r_cnt == 4'd9) w_fsm_nxt = S_INIT;
      end
      // rcon sits one step past 0x36 here, so stepping down yields 0x36.
      S_INIT: begin
        w_state_nxt = r_state ^ r_key;
        w_key_nxt   = key_inv(r_key, w_rc_dn);
        w_rcon_nxt  = w_rc_dn;
        w_cnt_nxt   = 4'd9;
        w_fsm_nxt   = S_ROUND;
      end
      S_ROUND: begin
        w_state_nxt = w_mix;
        w_key_nxt   = key_inv(r_key, w_rc_dn);
        w_rcon_nxt  = w_rc_dn;
        w_cnt_nxt   = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_fsm_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_state_nxt = w_add;
        w_pt_nxt    = w_add;
        w_ov_nxt    = 1'b1;
        w_fsm_nxt   = S_DONE;
      end
      S_DONE: if (out_ready) begin
        w_ov_nxt  = 1'b0;
        w_fsm_nxt = S_IDLE;
        if (WIPE_ON_IDLE) begin
          w_state_nxt = '0;
          w_key_nxt   = '0;
          w_rcon_nxt  = '0;
          w_cnt_nxt   = '0;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_key       <= '0;
      r_pt        <= '0;
      r_rcon      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_key       <= w_key_nxt;
      r_pt        <= w_pt_nxt;
      r_rcon      <= w_rcon_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= w_ov_nxt;
      r_in_ready  <= (w_fsm_nxt == S_IDLE);
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign plan_text_128 = r_pt;
  assign busy          = (r_fsm != S_IDLE);
endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Bench for aes128_decrypt_iter: known-answer vectors, latency, backpressure,
// busy-input ignore, mid-run reset and back-to-back streaming.
module tb_aes128_decrypt_iter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [127:0] ct = '0, key = '0, pt;

  aes128_decrypt_iter #(.WIPE_ON_IDLE(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .cipher_text_128 (ct),
    .cipher_key_128  (key),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .plan_text_128   (pt),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] sb[$];
  logic [127:0] exp_drv = '0;
  int           acc_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           n_out = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edges push the expected plaintext into the scoreboard.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(exp_drv);
      acc_q.push_back(cyc);
    end
    cyc++;
  end

  always @(negedge clk) begin : mon
    logic [127:0] e;
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%h required=none", pt);
      end else begin
        e = sb.pop_front();
        chk("plaintext", pt, e);
      end
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n;
    n = 0;
    key = k; ct = c; exp_drv = p; in_valid = 1'b1;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int           lat, bad, n0, seen_idle, swapped, n;
    logic [127:0] hold;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{key: 128'h00000000000000000000000000000000,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                pt:  128'h00000000000000000000000000000000};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3ad77bb40d7a3660a89ecaf32466ef97,
                pt:  128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[4] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'hf5d3d58503b9699de785895a96fdbaaf,
                pt:  128'hae2d8a571e03ac9c9eb76fac45af8e51};

    #12;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_pt", pt, 128'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 128'(in_ready), 128'(1));

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].key, vecs[i].ct, vecs[i].pt);
      wait_out(lat);
      chk("latency", 128'(lat), 128'(21));
      tick();
    end

    // Backpressure: hold the result for 50 clocks.
    out_ready = 1'b0;
    send(vecs[0].key, vecs[0].ct, vecs[0].pt);
    wait_out(lat);
    chk("bp_latency", 128'(lat), 128'(21));
    hold = pt;
    bad = 0;
    repeat (50) begin
      tick();
      if (!out_valid || pt !== hold || in_ready) bad++;
    end
    chk("bp_stall_stable", 128'(bad), 128'(0));
    chk("bp_held_pt", hold, vecs[0].pt);
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", 128'(out_valid), 128'(0));
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    chk("bp_pt_kept", pt, vecs[0].pt);

    // Garbage pulses while busy must be ignored.
    n0 = n_out;
    send(vecs[0].key, vecs[0].ct, vecs[0].pt);
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == 4 || lat == 14) begin
        in_valid = 1'b1;
        key = {4{32'hdeadbeef}};
        ct = {4{32'h0badf00d}};
      end else begin
        in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk("busy_ign_latency", 128'(lat), 128'(21));
    tick();
    repeat (30) tick();
    chk("busy_ign_one_output", 128'(n_out - n0), 128'(1));

    // Mid-run reset discards the block in flight.
    send(vecs[0].key, vecs[0].ct, vecs[0].pt);
    repeat (11) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_pt", pt, 128'h0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    n0 = n_out;
    send(vecs[1].key, vecs[1].ct, vecs[1].pt);
    wait_out(lat);
    chk("post_rst_latency", 128'(lat), 128'(21));
    tick();
    chk("post_rst_one_output", 128'(n_out - n0), 128'(1));

    // Back-to-back with in_valid held high.
    n0 = acc_q.size();
    seen_idle = 0;
    swapped = 0;
    n = 0;
    key = vecs[0].key; ct = vecs[0].ct; exp_drv = vecs[0].pt; in_valid = 1'b1;
    while (acc_q.size() < n0 + 2 && n < 200) begin
      tick();
      n++;
      if (acc_q.size() == n0 + 1 && swapped == 0) begin
        swapped = 1;
        key = vecs[1].key; ct = vecs[1].ct; exp_drv = vecs[1].pt;
      end
      if (acc_q.size() == n0 + 1 && !busy && seen_idle == 0) begin
        seen_idle = 1;
        chk("wipe_key", dut.r_key, 128'h0);
      end
    end
    in_valid = 1'b0;
    chk("b2b_idle_seen", 128'(seen_idle), 128'(1));
    if (acc_q.size() >= n0 + 2)
      chk("b2b_spacing", 128'(acc_q[n0+1] - acc_q[n0]), 128'(23));
    else
      chk("b2b_accepts", 128'(acc_q.size() - n0), 128'(2));
    wait_out(lat);
    chk("b2b_latency", 128'(lat), 128'(21));
    tick();
    repeat (5) tick();
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes128_decrypt_iter.md
Name: aes128_decrypt_iter

Overview:
- Iterative, clocked AES-128 decryption engine: one round per clock, valid/ready handshakes on input and output.
- It is the receive-side counterpart of the team's combinational AES-128 encrypt path. It takes ciphertext plus the original cipher key and returns plaintext.
- The decryption key schedule is generated on the fly: forward expansion to round key 10 first, then inverse expansion back down to round key 0.
- Sits between the link/DMA receiver and plaintext consumers; replaces the combinational decrypt path where timing closure matters.

Parameters:
- WIPE_ON_IDLE, 1, when 1 the internal state and key registers are cleared to 0 on every return to IDLE; when 0 they hold their last value.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  cipher_text_128/cipher_key_128 valid
- in_ready  output  1  engine can accept a block
- cipher_text_128  input  128  ciphertext; [127:120] = byte 0 (FIPS-197 column-major order)
- cipher_key_128  input  128  AES-128 cipher key (round key 0), same byte order
- out_valid  output  1  plan_text_128 valid
- out_ready  input  1  consumer accepts plan_text_128
- plan_text_128  output  128  recovered plaintext
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: in_ready=0 while rst_n low, 1 on the first clk after release. out_valid=0, plan_text_128=0, busy=0, all state/key registers=0, FSM=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch the ciphertext into the state register, latch the key into the round-key register, set rcon=0x01, go to KEXP.
  - KEXP: 10 cycles. Each cycle applies one forward key-expansion step (RotWord/SubWord/rcon) and advances rcon (xtime). After the 10th step the register holds rk10; go to INIT.
  - INIT: 1 cycle. state ^= rk10. Apply one inverse key step (rk10 -> rk9, rcon 0x36). Round counter=9. Go to ROUND.
  - ROUND: 9 cycles. state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_cur). Then rk_cur -> rk_prev and rcon steps down (inverse xtime: 0x36, 0x1b, 0x80, ... 0x01). When the counter reaches 1, go to FINAL.
  - FINAL: 1 cycle. state = InvSubBytes(InvShiftRows(state)) ^ rk0. Load plan_text_128, set out_valid=1, go to DONE.
  - DONE: hold plan_text_128 and out_valid stable until out_ready=1. On out_valid&out_ready: out_valid<=0, go to IDLE, and wipe registers if WIPE_ON_IDLE=1. plan_text_128 keeps its value after the handshake.
- Inverse key step: w0'=w0^SubWord(RotWord(w3')), where w3'=w3^w2, w2'=w2^w1, w1'=w1^w0.
- Latency: accept edge to out_valid=1 is exactly 21 clocks (10 KEXP + 1 INIT + 9 ROUND + 1 FINAL).
- Throughput: with out_ready tied high, one block per 23 clocks (21 + 1 DONE + 1 IDLE).
- Input handshake: in_ready is 0 in every state except IDLE. in_valid while in_ready=0 is ignored and the inputs are not sampled. Inputs are sampled only at the accept edge; later changes to them have no effect.
- Output handshake: out_ready high before out_valid has no effect. A stall in DONE is unbounded with no data loss.
- S-box and inverse S-box are combinational FIPS-197 lookups. All GF(2^8) arithmetic uses reduction polynomial 0x11b.
- Reset mid-operation: the FSM returns to IDLE immediately and asynchronously. out_valid drops, no partial result is ever presented, and the block in flight is discarded.
- In DONE with out_ready=1 and in_valid=1 in the same cycle, no new block is accepted that cycle; it is accepted in the following IDLE cycle.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> plan_text_128=3243f6a8885a308d313198a2e0370734, out_valid exactly 21 clocks after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- Backpressure: out_ready=0 for 50 clocks after out_valid -> out_valid and plan_text stay stable, in_ready=0 throughout; out_ready=1 -> one handshake, then in_ready=1 next clock.
- Busy-input ignore: pulse in_valid with garbage ct/key at clocks 5 and 15 after accept -> result still the App. B plaintext; no second output appears.
- Reset mid-run: assert rst_n=0 at clock 12 after accept -> out_valid=0, busy=0 at once. Then issue App. C.1 -> correct result after 21 clocks; no stale output.
- Back-to-back: stream both vectors with out_ready=1 and in_valid held -> outputs in order; accepts 23 clocks apart; with WIPE_ON_IDLE=1 the internal key register reads 0 in the IDLE cycle.
